line_buffer_ctrl: RTL
=====================

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 Parameter IMG_W, default 577: pixels per line; equals the line-buffer depth.
REQ-002 Parameter IMG_H, default 480: lines per frame.
REQ-003 Parameter WIN, default 7: window height/width; equals the number of chained line buffers.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sof  input  1  start-of-frame pulse, single cycle.
REQ-007 pix_valid  input  1  pix_in carries a pixel this cycle.
REQ-008 pix_in  input  8  incoming pixel.
REQ-009 lb_en  output  1  shift enable to the line-buffer chain.
REQ-010 lb_din  output  8  data to the first line buffer.
REQ-011 win_valid  output  1  the WINxWIN window at taps is complete.
REQ-012 win_row, win_col  output  CW=$clog2(max(IMG_W,IMG_H))  coordinates of the newest pixel in the window.
REQ-013 frame_done  output  1  single-cycle end-of-frame pulse.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, FILL, RUN, FLUSH (macro only), DONE.
REQ-016 IDLE->FILL on sof; FILL->RUN when the pixel at row WIN-1, col 0 is accepted; RUN->DONE on the last pixel (row IMG_H-1, col IMG_W-1), or RUN->FLUSH with the macro; DONE->IDLE after one cycle.
REQ-017 A pixel is accepted when pix_valid=1 in FILL or RUN; lb_en = accept, combinational; lb_din = pix_in.
REQ-018 Inputs with pix_valid=1 in IDLE or DONE shall be ignored, with lb_en=0.
REQ-019 col increments on each accept and wraps from IMG_W-1 to 0; on wrap, row increments; no other wrap arithmetic.
REQ-020 win_valid shall be registered: high the cycle after an accept whose row>=WIN-1 and col>=WIN-1; win_row/win_col hold that pixel's coordinates.
REQ-021 win_row/win_col shall hold their value while win_valid=0.
REQ-022 frame_done is high for exactly one cycle, in DONE.
REQ-023 sof in FILL, RUN or FLUSH: counters clear to 0, state goes to FILL, and the sof cycle's pixel is accepted as (0,0); no frame_done is produced for the aborted frame.
REQ-024 sof and pix_valid in the same cycle in IDLE: transition to FILL and accept the pixel as (0,0).

Reset
REQ-025 On rst_n=0: state=IDLE; col, row, win_row and win_col = 0; win_valid, frame_done and busy = 0.
REQ-026 Reset mid-frame abandons the frame; line-buffer contents are not cleared and are stale until WIN-1 new lines are written.

Configuration
REQ-027 Macro LBC_FLUSH_EN, when defined, enables the FLUSH state: after the last pixel, the block drives lb_en=1 and lb_din=0 every cycle for (WIN/2)*IMG_W cycles, continuing row/col counting and win_valid generation, then enters DONE.
REQ-028 Without LBC_FLUSH_EN: no FLUSH state; RUN->DONE directly; bottom-border windows are not emitted.

Structure
REQ-029 Package lbc_pkg holds the state enum type and the defaults LBC_IMG_W=577, LBC_IMG_H=480 and LBC_WIN=7.
REQ-030 One sub-module, lbc_xy_cnt, implements the col/row counter with clear, increment and wrap outputs.

Verification (IMG_W=8, IMG_H=6, WIN=3)
REQ-031 Reset, then sof, then 48 contiguous pixels -> 48 lb_en pulses; first win_valid the cycle after pixel (2,2); 24 win_valid pulses total; frame_done once.
REQ-032 Pixels with pix_valid toggling 1/0 -> same 24 windows and coordinates as REQ-031; win_valid never high in a cycle that does not follow an accept.
REQ-033 sof asserted at pixel (3,5) of a frame -> counters restart at (0,0); no frame_done for that frame; the next full frame behaves as REQ-031.
REQ-034 rst_n pulsed low mid-RUN -> all outputs 0 immediately (asynchronous); the block stays IDLE until sof.
REQ-035 With LBC_FLUSH_EN defined -> 8 zero-data lb_en cycles after the last pixel; win_valid for rows 6 (cols 2..7); frame_done follows the flush.
REQ-036 pix_valid=1 in IDLE with no sof -> lb_en stays 0; counters unchanged.

Source files
------------

// File: rtl/lbc_pkg.sv
// rtl/lbc_pkg.sv - shared state type, default geometry and width helper for line_buffer_ctrl
package lbc_pkg;

  localparam int LBC_IMG_W = 577;
  localparam int LBC_IMG_H = 480;
  localparam int LBC_WIN   = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
`ifdef LBC_FLUSH_EN
    ST_FLUSH = 3'd3,
`endif
    ST_DONE  = 3'd4
  } lbc_state_e;

  function automatic int lbc_cw(input int w, input int h);
    return $clog2((w > h) ? w : h);
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// rtl/line_buffer_ctrl_if.sv - pixel input and line-buffer/window output bundle
interface line_buffer_ctrl_if #(
  parameter int CW = 10
);
  logic          sof;
  logic          pix_valid;
  logic [7:0]    pix_in;
  logic          lb_en;
  logic [7:0]    lb_din;
  logic          win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;
  logic          busy;

  modport master (
    output sof, pix_valid, pix_in,
    input  lb_en, lb_din, win_valid, win_row, win_col, frame_done, busy
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output lb_en, lb_din, win_valid, win_row, win_col, frame_done, busy
  );
endinterface

// File: rtl/lbc_xy_cnt.sv
// rtl/lbc_xy_cnt.sv - raster col/row counter; outputs are the coordinates of the pixel accepted this cycle
module lbc_xy_cnt #(
  parameter int IMG_W = 577,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] row_o,
  output logic          wrap_o
);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_cur, row_cur;

  // A clear in the same cycle as an increment makes this cycle's pixel (0,0).
  always_comb begin
    col_cur = clr_i ? '0 : col_q;
    row_cur = clr_i ? '0 : row_q;
    wrap_o  = inc_i && (col_cur == CW'(IMG_W - 1));
    col_d   = col_cur;
    row_d   = row_cur;
    if (inc_i) begin
      if (wrap_o) begin
        col_d = '0;
        row_d = row_cur + CW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_cur;
  assign row_o = row_cur;

endmodule

// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - line-buffer chain controller with window tracking; LBC_FLUSH_EN adds a bottom-border flush
module line_buffer_ctrl
  import lbc_pkg::*;
#(
  parameter int IMG_W = LBC_IMG_W,
  parameter int IMG_H = LBC_IMG_H,
  parameter int WIN   = LBC_WIN
) (
  input  logic             clk,
  input  logic             rst_n,
  line_buffer_ctrl_if.slave bus
);

  localparam int CW = lbc_cw(IMG_W, IMG_H);

  lbc_state_e    state_q, state_d;
  logic          accept;
  logic          flushing;
  logic          sof_start;
  logic          wrap;
  logic [CW-1:0] col_cur, row_cur;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_row_q, win_col_q;

`ifdef LBC_FLUSH_EN
  localparam int FLUSH_N = (WIN / 2) * IMG_W;
  localparam int FW      = (FLUSH_N > 1) ? $clog2(FLUSH_N + 1) : 1;
  localparam int FLUSH_LAST = (FLUSH_N > 0) ? FLUSH_N - 1 : 0;

  logic [FW-1:0] flush_cnt_q, flush_cnt_d;

  assign flushing    = (state_q == ST_FLUSH) && !bus.sof;
  assign flush_cnt_d = (state_q == ST_FLUSH) ? flush_cnt_q + FW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_cnt_q <= '0;
    else        flush_cnt_q <= flush_cnt_d;
  end
`else
  assign flushing = 1'b0;
`endif

  // sof restarts the frame from any active state; DONE finishes out its single cycle.
  assign sof_start = bus.sof && (state_q != ST_DONE);
  assign accept    = flushing ||
                     (bus.pix_valid && (sof_start || state_q == ST_FILL || state_q == ST_RUN));

  lbc_xy_cnt #(
    .IMG_W (IMG_W),
    .CW    (CW)
  ) u_xy_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (sof_start),
    .inc_i  (accept),
    .col_o  (col_cur),
    .row_o  (row_cur),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.sof) state_d = ST_FILL;
      ST_FILL: begin
        if (bus.sof) state_d = ST_FILL;
        else if (accept && row_cur == CW'(WIN - 1) && col_cur == '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.sof) state_d = ST_FILL;
        else if (wrap && row_cur == CW'(IMG_H - 1)) begin
`ifdef LBC_FLUSH_EN
          state_d = (FLUSH_N > 0) ? ST_FLUSH : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef LBC_FLUSH_EN
      ST_FLUSH: begin
        if (bus.sof) state_d = ST_FILL;
        else if (flush_cnt_q == FW'(FLUSH_LAST)) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign win_valid_d = accept && (row_cur >= CW'(WIN - 1)) && (col_cur >= CW'(WIN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      if (win_valid_d) begin
        win_row_q <= row_cur;
        win_col_q <= col_cur;
      end
    end
  end

  assign bus.lb_en      = accept;
  assign bus.lb_din     = flushing ? 8'h00 : bus.pix_in;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
